// File: rtl/aespim_key_schedule.sv
// Word-serial AES-128/192/256 key schedule: key words in, expanded schedule out over valid/ready.
// Define AESPIM_KS_AES256_EN for AES-256 support (8-word window and the i mod 8 == 4 SubWord path).

module aespim_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [2047:0] SboxTbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  assign o_byte = SboxTbl[{~i_byte, 3'b000} +: 8];

endmodule

module aespim_key_schedule #(
  parameter int unsigned SKIP_KEY_WORDS = 0,
  parameter int unsigned IDX_W          = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       key_len_i,
  input  logic             abort_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [31:0]      key_i,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [31:0]      rk_o,
  output logic [IDX_W-1:0] rk_idx_o,
  output logic             rk_last_o,
  output logic             busy_o,
  output logic             err_o
);

`ifdef AESPIM_KS_AES256_EN
  localparam int WinDepth = 8;
`else
  localparam int WinDepth = 6;
`endif

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;
  typedef logic [WinDepth-1:0][31:0] win_t;

  // Slots 0..Nk-1 hold w[i-Nk]..w[i-1]; a new word enters at slot Nk-1.
  function automatic win_t win_shift(input win_t win, input logic [2:0] top, input logic [31:0] w);
    win_t res;
    res = win;
    for (int j = 0; j < WinDepth - 1; j++) begin
      if (j < int'(top)) res[j] = win[j+1];
    end
    res[top] = w;
    return res;
  endfunction

  state_e           r_state, w_state_nxt;
  win_t             r_win, w_win_nxt, w_win_a;
  logic [2:0]       r_top, w_top_nxt;
  logic [5:0]       r_last_idx, w_last_nxt;
  logic [2:0]       r_kcnt, w_kcnt_nxt;
  logic [5:0]       r_nidx, w_nidx_nxt;
  logic [2:0]       r_mod, w_mod_nxt;
  logic [7:0]       r_rcon, w_rcon_nxt;
  logic [31:0]      r_rk, w_rk_nxt;
  logic [IDX_W-1:0] r_rk_idx, w_rk_idx_nxt;
  logic             r_rk_last, w_rk_last_nxt;
  logic             r_rk_valid, w_rk_valid_nxt;
  logic             r_err, w_err_nxt;

  logic             w_key_hs, w_load, w_is_key, w_legal;
  logic [2:0]       w_top_sel;
  logic [5:0]       w_last_sel;
  logic [31:0]      w_prev, w_old, w_sub_in, w_sub, w_temp, w_gen;
  logic [7:0]       w_rcon_x;

  assign w_key_hs = (r_state == StLoad) && key_valid_i;
  // Generation reads the window as it will look after this cycle's key word lands.
  assign w_win_a  = w_key_hs ? win_shift(r_win, r_top, key_i) : r_win;
  assign w_prev   = w_win_a[r_top];
  assign w_old    = w_win_a[0];
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_rcon_x = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_is_key = (r_nidx <= {3'b000, r_top});

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aespim_sbox u_sbox (
      .i_byte (w_sub_in[8*b +: 8]),
      .o_byte (w_sub[8*b +: 8])
    );
  end

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h000000};
`ifdef AESPIM_KS_AES256_EN
    end else if ((r_top == 3'd7) && (r_mod == 3'd4)) begin
      w_temp = w_sub;
`endif
    end
  end

  assign w_gen = w_old ^ w_temp;

  always_comb begin
    w_legal    = 1'b1;
    w_top_sel  = 3'd3;
    w_last_sel = 6'd43;
    case (key_len_i)
      2'b00: begin
        w_top_sel  = 3'd3;
        w_last_sel = 6'd43;
      end
      2'b01: begin
        w_top_sel  = 3'd5;
        w_last_sel = 6'd51;
      end
`ifdef AESPIM_KS_AES256_EN
      2'b10: begin
        w_top_sel  = 3'd7;
        w_last_sel = 6'd59;
      end
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_top_nxt      = r_top;
    w_last_nxt     = r_last_idx;
    w_kcnt_nxt     = r_kcnt;
    w_nidx_nxt     = r_nidx;
    w_mod_nxt      = r_mod;
    w_rcon_nxt     = r_rcon;
    w_rk_nxt       = r_rk;
    w_rk_idx_nxt   = r_rk_idx;
    w_rk_last_nxt  = r_rk_last;
    w_rk_valid_nxt = r_rk_valid;
    w_err_nxt      = 1'b0;
    w_load         = 1'b0;

    case (r_state)
      StIdle: begin
        if (start_i) begin
          if (w_legal) begin
            w_state_nxt = StLoad;
            w_top_nxt   = w_top_sel;
            w_last_nxt  = w_last_sel;
            w_kcnt_nxt  = 3'd0;
            w_mod_nxt   = 3'd0;
            w_rcon_nxt  = 8'h01;
            w_nidx_nxt  = (SKIP_KEY_WORDS != 0) ? ({3'b000, w_top_sel} + 6'd1) : 6'd0;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      StLoad: begin
        if (key_valid_i) begin
          w_win_nxt  = w_win_a;
          w_kcnt_nxt = r_kcnt + 3'd1;
          if (r_kcnt == r_top) begin
            w_state_nxt = StEmit;
            w_load      = 1'b1;
          end
        end
      end
      StEmit: begin
        if (r_rk_valid && rk_ready_i) begin
          if (r_rk_last) begin
            w_state_nxt    = StIdle;
            w_rk_valid_nxt = 1'b0;
            w_rk_last_nxt  = 1'b0;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    if (w_load) begin
      w_rk_valid_nxt = 1'b1;
      w_rk_idx_nxt   = IDX_W'(r_nidx);
      w_rk_last_nxt  = (r_nidx == r_last_idx);
      w_nidx_nxt     = r_nidx + 6'd1;
      w_mod_nxt      = (r_mod == r_top) ? 3'd0 : r_mod + 3'd1;
      if (w_is_key) begin
        w_rk_nxt = w_win_a[r_nidx[2:0]];
      end else begin
        w_rk_nxt  = w_gen;
        w_win_nxt = win_shift(w_win_a, r_top, w_gen);
        if (r_mod == 3'd0) w_rcon_nxt = w_rcon_x;
      end
    end

    if (abort_i) begin
      w_state_nxt    = StIdle;
      w_win_nxt      = '0;
      w_top_nxt      = 3'd3;
      w_last_nxt     = 6'd43;
      w_kcnt_nxt     = 3'd0;
      w_nidx_nxt     = 6'd0;
      w_mod_nxt      = 3'd0;
      w_rcon_nxt     = 8'h01;
      w_rk_nxt       = 32'h0;
      w_rk_idx_nxt   = '0;
      w_rk_last_nxt  = 1'b0;
      w_rk_valid_nxt = 1'b0;
      w_err_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_win      <= '0;
      r_top      <= 3'd3;
      r_last_idx <= 6'd43;
      r_kcnt     <= 3'd0;
      r_nidx     <= 6'd0;
      r_mod      <= 3'd0;
      r_rcon     <= 8'h01;
      r_rk       <= 32'h0;
      r_rk_idx   <= '0;
      r_rk_last  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_win      <= w_win_nxt;
      r_top      <= w_top_nxt;
      r_last_idx <= w_last_nxt;
      r_kcnt     <= w_kcnt_nxt;
      r_nidx     <= w_nidx_nxt;
      r_mod      <= w_mod_nxt;
      r_rcon     <= w_rcon_nxt;
      r_rk       <= w_rk_nxt;
      r_rk_idx   <= w_rk_idx_nxt;
      r_rk_last  <= w_rk_last_nxt;
      r_rk_valid <= w_rk_valid_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign key_ready_o = (r_state == StLoad);
  assign busy_o      = (r_state != StIdle);
  assign rk_valid_o  = r_rk_valid;
  assign rk_o        = r_rk;
  assign rk_idx_o    = r_rk_idx;
  assign rk_last_o   = r_rk_last;
  assign err_o       = r_err;

endmodule
